// File: rtl/debug_link_master.sv
// debug_link_master: host-side initiator for the MIPS debug UART protocol.
// Optional feature macro DEBUG_LINK_TIMEOUT_EN: abort RX_WAIT after RX_TIMEOUT idle cycles.
//
// state   | meaning
// IDLE    | waiting for a request
// TX_BYTE | o_tx_start pulse for the byte held in o_tx_data
// TX_WAIT | waiting for uart_tx to finish the byte
// FETCH   | latching the next LOAD word from the program ROM
// RX_WAIT | forwarding response bytes
// DONE    | o_done pulse, then back to IDLE
module debug_link_master #(
  parameter int NUM_REGISTERS   = 32,
  parameter int PROG_ADDR_WIDTH = 8,
  parameter int RX_TIMEOUT      = 1000000
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_cmd_valid,
  input  logic [2:0]                 i_cmd,
  input  logic [7:0]                 i_cmd_arg,
  output logic [PROG_ADDR_WIDTH-1:0] o_prog_addr,
  input  logic [31:0]                i_prog_data,
  output logic [7:0]                 o_tx_data,
  output logic                       o_tx_start,
  input  logic                       i_tx_done,
  input  logic [7:0]                 i_rx_data,
  input  logic                       i_rx_valid,
  output logic                       o_busy,
  output logic [7:0]                 o_resp_data,
  output logic                       o_resp_valid,
  output logic [15:0]                o_resp_index,
  output logic                       o_done,
  output logic                       o_error
);

  localparam logic [2:0] OP_LOAD       = 3'd0;
  localparam logic [2:0] OP_DUMP_REGS  = 3'd1;
  localparam logic [2:0] OP_READ_MEM   = 3'd2;
  localparam logic [2:0] OP_STEP       = 3'd3;
  localparam logic [2:0] OP_MODE_CONT  = 3'd4;
  localparam logic [2:0] OP_MODE_STEP  = 3'd5;
  localparam logic [2:0] OP_READ_IF_ID = 3'd6;
  localparam logic [2:0] OP_RESERVED   = 3'd7;

  localparam logic [15:0] DUMP_BYTES = 16'(NUM_REGISTERS * 4);

  if (RX_TIMEOUT < 1) begin : g_bad_timeout
    $error("RX_TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE, TX_BYTE, TX_WAIT, FETCH, RX_WAIT, DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_CMD, PH_ARG, PH_WORD, PH_TAIL
  } phase_t;

  state_t      state;
  phase_t      phase;
  logic [2:0]  op;
  logic [7:0]  arg;
  logic [7:0]  words_left;
  logic [1:0]  bytes_left;
  logic [31:0] word_buf;
  logic [15:0] resp_left;
  logic [15:0] rx_idx;
  logic        seq_end;
  logic        go_fetch;

`ifdef DEBUG_LINK_TIMEOUT_EN
  localparam int               TMR_W    = $clog2(RX_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(RX_TIMEOUT - 1);
  logic [TMR_W-1:0] rx_timer;
`endif

  function automatic logic [7:0] cmd_byte(input logic [2:0] op_code);
    case (op_code)
      OP_LOAD:       return 8'h07;
      OP_DUMP_REGS:  return 8'h01;
      OP_READ_MEM:   return 8'h0B;
      OP_STEP:       return 8'h0A;
      OP_MODE_CONT:  return 8'h08;
      OP_MODE_STEP:  return 8'h09;
      OP_READ_IF_ID: return 8'h02;
      default:       return 8'h00;
    endcase
  endfunction

  function automatic logic [15:0] resp_count(input logic [2:0] op_code);
    case (op_code)
      OP_DUMP_REGS:               return DUMP_BYTES;
      OP_READ_MEM, OP_READ_IF_ID: return 16'd4;
      default:                    return 16'd0;
    endcase
  endfunction

  // What follows the byte that just finished: end of sequence, a ROM fetch, or another byte
  always_comb begin
    seq_end  = 1'b0;
    go_fetch = 1'b0;
    case (phase)
      PH_CMD:  seq_end = (op != OP_LOAD) && (op != OP_READ_MEM);
      PH_ARG:  begin
        seq_end  = (op != OP_LOAD);
        go_fetch = (op == OP_LOAD);
      end
      PH_WORD: go_fetch = (bytes_left == 2'd0) && (words_left != 8'd0);
      default: seq_end = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= IDLE;
      phase        <= PH_CMD;
      op           <= '0;
      arg          <= '0;
      words_left   <= '0;
      bytes_left   <= '0;
      word_buf     <= '0;
      resp_left    <= '0;
      rx_idx       <= '0;
      o_prog_addr  <= '0;
      o_tx_data    <= '0;
      o_tx_start   <= 1'b0;
      o_busy       <= 1'b0;
      o_resp_data  <= '0;
      o_resp_valid <= 1'b0;
      o_resp_index <= '0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
`ifdef DEBUG_LINK_TIMEOUT_EN
      rx_timer     <= '0;
`endif
    end else begin
      o_tx_start   <= 1'b0;
      o_resp_valid <= 1'b0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
      case (state)
        IDLE: begin
          if (i_cmd_valid) begin
            op         <= i_cmd;
            arg        <= i_cmd_arg;
            words_left <= i_cmd_arg;
            resp_left  <= resp_count(i_cmd);
            rx_idx     <= '0;
            o_busy     <= 1'b1;
            if (i_cmd == OP_RESERVED || (i_cmd == OP_LOAD && i_cmd_arg == 8'd0)) begin
              state   <= DONE;
              o_done  <= 1'b1;
              o_error <= (i_cmd == OP_LOAD);
            end else begin
              state      <= TX_BYTE;
              phase      <= PH_CMD;
              o_tx_data  <= cmd_byte(i_cmd);
              o_tx_start <= 1'b1;
            end
          end
        end
        TX_BYTE: state <= TX_WAIT;
        TX_WAIT: begin
          if (i_tx_done) begin
            if (seq_end) begin
              if (resp_left != 16'd0) begin
                state <= RX_WAIT;
`ifdef DEBUG_LINK_TIMEOUT_EN
                rx_timer <= TMR_LOAD;
`endif
              end else begin
                state  <= DONE;
                o_done <= 1'b1;
              end
            end else if (go_fetch) begin
              state <= FETCH;
            end else begin
              state      <= TX_BYTE;
              o_tx_start <= 1'b1;
              if (phase == PH_CMD) begin
                phase     <= PH_ARG;
                o_tx_data <= arg;
              end else if (bytes_left != 2'd0) begin
                bytes_left <= bytes_left - 2'd1;
                o_tx_data  <= word_buf[7:0];
                word_buf   <= {8'h00, word_buf[31:8]};
              end else begin
                phase     <= PH_TAIL;
                o_tx_data <= 8'h11;
              end
            end
          end
        end
        // The ROM address already points at this word, so its data is valid here
        FETCH: begin
          word_buf    <= {8'h00, i_prog_data[31:8]};
          o_tx_data   <= i_prog_data[7:0];
          o_tx_start  <= 1'b1;
          bytes_left  <= 2'd3;
          words_left  <= words_left - 8'd1;
          o_prog_addr <= o_prog_addr + PROG_ADDR_WIDTH'(1);
          phase       <= PH_WORD;
          state       <= TX_BYTE;
        end
        RX_WAIT: begin
          if (resp_left == 16'd0) begin
            state  <= DONE;
            o_done <= 1'b1;
          end else if (i_rx_valid) begin
            o_resp_valid <= 1'b1;
            o_resp_data  <= i_rx_data;
            o_resp_index <= rx_idx;
            rx_idx       <= rx_idx + 16'd1;
            resp_left    <= resp_left - 16'd1;
`ifdef DEBUG_LINK_TIMEOUT_EN
            rx_timer     <= TMR_LOAD;
          end else if (rx_timer == '0) begin
            state   <= DONE;
            o_done  <= 1'b1;
            o_error <= 1'b1;
          end else begin
            rx_timer <= rx_timer - TMR_W'(1);
`endif
          end
        end
        DONE: begin
          o_busy      <= 1'b0;
          o_prog_addr <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_link_master.sv
// Directed bench for debug_link_master with a ROM model and a fixed-latency uart_tx model.
module tb_debug_link_master;
  localparam int AW     = 8;
  localparam int TOUT   = 100;
  localparam int TX_LAT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [2:0]    cmd = '0;
  logic [7:0]    cmd_arg = '0;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_data = '0;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_done = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          busy;
  logic [7:0]    resp_data;
  logic          resp_valid;
  logic [15:0]   resp_index;
  logic          done;
  logic          error;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int tx_cnt = 0;
  int n_done = 0;
  int last_done_cyc = 0;
  int acc_cyc = 0;
  int done_base = 0;
  logic last_err = 1'b0;
  logic last_done_busy = 1'b0;

  logic [31:0] rom [256];
  logic [7:0]  tx_log [$];
  int          tx_start_cyc [$];
  int          tx_done_cyc [$];
  logic [7:0]  resp_log [$];
  logic [15:0] ridx_log [$];
  int          resp_cyc [$];

  debug_link_master #(
    .NUM_REGISTERS(32),
    .PROG_ADDR_WIDTH(AW),
    .RX_TIMEOUT(TOUT)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_cmd_valid(cmd_valid),
    .i_cmd(cmd),
    .i_cmd_arg(cmd_arg),
    .o_prog_addr(prog_addr),
    .i_prog_data(prog_data),
    .o_tx_data(tx_data),
    .o_tx_start(tx_start),
    .i_tx_done(tx_done),
    .i_rx_data(rx_data),
    .i_rx_valid(rx_valid),
    .o_busy(busy),
    .o_resp_data(resp_data),
    .o_resp_valid(resp_valid),
    .o_resp_index(resp_index),
    .o_done(done),
    .o_error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) prog_data <= rom[prog_addr];

  // uart_tx model plus event logging; cycle stamps name the cycle the signal was high
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_cnt  <= 0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (tx_start) begin
        tx_log.push_back(tx_data);
        tx_start_cyc.push_back(cyc);
        tx_cnt <= TX_LAT;
      end else if (tx_cnt == 1) begin
        tx_done <= 1'b1;
        tx_cnt  <= 0;
      end else if (tx_cnt > 1) begin
        tx_cnt <= tx_cnt - 1;
      end
      if (tx_done) tx_done_cyc.push_back(cyc);
      if (resp_valid) begin
        resp_log.push_back(resp_data);
        ridx_log.push_back(resp_index);
        resp_cyc.push_back(cyc);
      end
      if (done) begin
        n_done++;
        last_done_cyc  = cyc;
        last_err       = error;
        last_done_busy = busy;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] txb(input int k);
    return (k < tx_log.size()) ? {24'h0, tx_log[k]} : 32'hFFFF_FFFF;
  endfunction

  function automatic int txs(input int k);
    return (k < tx_start_cyc.size()) ? tx_start_cyc[k] : -1000;
  endfunction

  function automatic int txd(input int k);
    return (k < tx_done_cyc.size()) ? tx_done_cyc[k] : -1000;
  endfunction

  function automatic int rsc(input int k);
    return (k < resp_cyc.size()) ? resp_cyc[k] : -1000;
  endfunction

  task automatic clear_logs();
    tx_log.delete();
    tx_start_cyc.delete();
    tx_done_cyc.delete();
    resp_log.delete();
    ridx_log.delete();
    resp_cyc.delete();
  endtask

  task automatic issue(input logic [2:0] c, input logic [7:0] a, input string tag);
    done_base = n_done;
    cmd       = c;
    cmd_arg   = a;
    cmd_valid = 1'b1;
    acc_cyc   = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk({tag, "_busy_rise"}, busy, 1);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k = 0;
    while (n_done == done_base && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done"}, n_done - done_base, 1);
    chk({tag, "_busy_fall"}, busy, 0);
    chk({tag, "_busy_at_done"}, last_done_busy, 1);
  endtask

  task automatic wait_tx(input int n, input int budget, input string tag);
    int k = 0;
    while (tx_done_cyc.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_tx_wait"}, tx_done_cyc.size() >= n, 1);
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] load_exp [11];
    logic [7:0] rm_exp [4];
    logic [2:0] m_op [3];
    logic [7:0] m_byte [3];
    int nd;

    load_exp = '{8'h07, 8'h02, 8'h05, 8'h00, 8'h01, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h11};
    rm_exp   = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    m_op     = '{3'd4, 3'd5, 3'd3};
    m_byte   = '{8'h08, 8'h09, 8'h0A};
    for (int i = 0; i < 256; i++) rom[i] = 32'hDEAD_0000 + i;
    rom[0] = 32'h2001_0005;
    rom[1] = 32'h0000_0000;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_prog_addr", prog_addr, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_index", resp_index, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // LOAD of two words with a stray request in the middle
    clear_logs();
    issue(3'd0, 8'd2, "load");
    repeat (8) @(negedge clk);
    cmd = 3'd3; cmd_arg = 8'h00; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done(300, "load");
    chk("load_tx_count", tx_log.size(), 11);
    for (int k = 0; k < 11; k++) chk($sformatf("load_tx[%0d]", k), txb(k), {24'h0, load_exp[k]});
    chk("load_first_start", txs(0) - acc_cyc, 1);
    for (int k = 1; k < 11; k++)
      chk($sformatf("load_gap[%0d]", k), txs(k) - txd(k - 1), (k == 2 || k == 6) ? 2 : 1);
    chk("load_done_time", last_done_cyc - txd(10), 1);
    chk("load_error", last_err, 0);
    chk("load_addr_zero", prog_addr, 0);

    // DUMP_REGS with a stray byte before RX_WAIT
    clear_logs();
    issue(3'd1, 8'h00, "dump");
    send_rx(8'hEE);
    wait_tx(1, 50, "dump");
    @(negedge clk);
    for (int i = 0; i < 128; i++) begin
      send_rx(i[7:0]);
      @(negedge clk);
    end
    wait_done(50, "dump");
    chk("dump_tx_count", tx_log.size(), 1);
    chk("dump_tx0", txb(0), 32'h01);
    chk("dump_resp_count", resp_log.size(), 128);
    for (int i = 0; i < 128; i++) begin
      if (i < resp_log.size()) begin
        chk($sformatf("dump_data[%0d]", i), resp_log[i], i);
        chk($sformatf("dump_index[%0d]", i), ridx_log[i], i);
      end
    end
    chk("dump_done_time", last_done_cyc - rsc(127), 1);
    chk("dump_error", last_err, 0);

    // READ_MEM with a fifth byte that must be dropped
    clear_logs();
    issue(3'd2, 8'h10, "rmem");
    wait_tx(2, 50, "rmem");
    @(negedge clk);
    send_rx(8'hAA);
    send_rx(8'hBB);
    send_rx(8'hCC);
    send_rx(8'hDD);
    send_rx(8'hEE);
    wait_done(50, "rmem");
    chk("rmem_tx_count", tx_log.size(), 2);
    chk("rmem_tx0", txb(0), 32'h0B);
    chk("rmem_tx1", txb(1), 32'h10);
    chk("rmem_resp_count", resp_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < resp_log.size()) begin
        chk($sformatf("rmem_data[%0d]", i), resp_log[i], rm_exp[i]);
        chk($sformatf("rmem_index[%0d]", i), ridx_log[i], i);
      end
    end
    chk("rmem_done_time", last_done_cyc - rsc(3), 1);
    chk("rmem_error", last_err, 0);

    // READ_IF_ID with only two response bytes
    clear_logs();
    issue(3'd6, 8'h00, "ifid");
    wait_tx(1, 50, "ifid");
    chk("ifid_tx0", txb(0), 32'h02);
    @(negedge clk);
    send_rx(8'h12);
    @(negedge clk);
    send_rx(8'h34);
`ifdef DEBUG_LINK_TIMEOUT_EN
    wait_done(TOUT + 50, "ifid_to");
    chk("ifid_to_resp_count", resp_log.size(), 2);
    chk("ifid_to_error", last_err, 1);
    chk("ifid_to_done_time", last_done_cyc - rsc(1), TOUT);
`else
    repeat (3 * TOUT) @(negedge clk);
    chk("ifid_no_done", n_done - done_base, 0);
    chk("ifid_still_busy", busy, 1);
    send_rx(8'h56);
    send_rx(8'h78);
    wait_done(50, "ifid");
    chk("ifid_resp_count", resp_log.size(), 4);
    chk("ifid_error", last_err, 0);
    chk("ifid_done_time", last_done_cyc - rsc(3), 1);
`endif

    // single-byte commands
    for (int m = 0; m < 3; m++) begin
      clear_logs();
      issue(m_op[m], 8'h5A, $sformatf("mode%0d", m));
      wait_done(50, $sformatf("mode%0d", m));
      chk($sformatf("mode%0d_tx_count", m), tx_log.size(), 1);
      chk($sformatf("mode%0d_tx0", m), txb(0), {24'h0, m_byte[m]});
      chk($sformatf("mode%0d_done_time", m), last_done_cyc - txd(0), 1);
      chk($sformatf("mode%0d_error", m), last_err, 0);
    end

    // LOAD with zero words, then the reserved opcode
    clear_logs();
    issue(3'd0, 8'd0, "load0");
    wait_done(20, "load0");
    chk("load0_done_time", last_done_cyc - acc_cyc, 1);
    chk("load0_error", last_err, 1);
    chk("load0_no_tx", tx_log.size(), 0);
    clear_logs();
    issue(3'd7, 8'd3, "rsvd");
    wait_done(20, "rsvd");
    chk("rsvd_done_time", last_done_cyc - acc_cyc, 1);
    chk("rsvd_error", last_err, 0);
    chk("rsvd_no_tx", tx_log.size(), 0);

    // reset in the middle of a LOAD, then a fresh STEP
    clear_logs();
    issue(3'd0, 8'd2, "lrst");
    wait_tx(3, 100, "lrst");
    rst = 1'b1;
    nd  = n_done;
    @(negedge clk);
    chk("lrst_busy", busy, 0);
    chk("lrst_tx_start", tx_start, 0);
    chk("lrst_tx_data", tx_data, 0);
    chk("lrst_prog_addr", prog_addr, 0);
    chk("lrst_done", done, 0);
    chk("lrst_error", error, 0);
    chk("lrst_resp_index", resp_index, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("lrst_no_done", n_done - nd, 0);
    chk("lrst_tx_count", tx_log.size(), 3);
    clear_logs();
    issue(3'd3, 8'h00, "step");
    wait_done(50, "step");
    chk("step_tx_count", tx_log.size(), 1);
    chk("step_tx0", txb(0), 32'h0A);
    chk("step_error", last_err, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
